// File: rtl/nes_pad_serializer_if.sv
// CPU-side controller port bundle: strobe level, per-read pulse and the serial pad bit.
// The CPU glue drives the master side and the pad serializer sits on the slave side.
interface nes_pad_serializer_if;
   logic ctlr_latch;
   logic ctlr_pulse;
   logic ctlr_data;

   modport master (
      output ctlr_latch,
      output ctlr_pulse,
      input  ctlr_data
   );

   modport slave (
      input  ctlr_latch,
      input  ctlr_pulse,
      output ctlr_data
   );
endinterface

// File: rtl/nes_pad_serializer.sv
// NES pad front end: synchronizes and debounces eight raw buttons, then serves them
// to the CPU one bit per read through an active-high shift register (A first).
module nes_pad_serializer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [7:0]                  buttons_raw,
   nes_pad_serializer_if.slave         ctlr,
   output logic [7:0]                  buttons_db,
   output logic [3:0]                  shift_cnt
);

   // The toggle fires on the edge where the counter would reach DEBOUNCE_CYCLES,
   // so the comparison is against one less than that.
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync1_q;
   logic [7:0]       sync2_q;
   logic [7:0][15:0] cnt_q;
   logic [7:0][15:0] cnt_d;
   logic [7:0]       db_q;
   logic [7:0]       db_d;
   logic [7:0]       sr_q;
   logic [7:0]       sr_d;
   logic [3:0]       shcnt_q;
   logic [3:0]       shcnt_d;
   logic             data_q;
   logic             data_d;

   // Two-flop synchronizer for the asynchronous pad inputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
      end else begin
         sync1_q <= buttons_raw;
         sync2_q <= sync1_q;
      end
   end

   // Per-button stability counters; any return to the accepted level restarts the count
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      for (int i = 0; i < 8; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = 16'd0;
         end else if (cnt_q[i] == DB_LAST) begin
            cnt_d[i] = 16'd0;
            db_d[i]  = ~db_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   // Latch has priority over pulse; SR only moves on a pulse once the latch is low
   always_comb begin
      sr_d    = sr_q;
      shcnt_d = shcnt_q;
      if (ctlr.ctlr_latch) begin
         sr_d    = db_q;
         shcnt_d = 4'd0;
      end else if (ctlr.ctlr_pulse) begin
         sr_d    = {1'b0, sr_q[7:1]};
         shcnt_d = (shcnt_q == 4'd8) ? 4'd8 : (shcnt_q + 4'd1);
      end else begin
         sr_d    = sr_q;
         shcnt_d = shcnt_q;
      end
      data_d = ~sr_d[0];
   end

   // State registers for debounce, shifter and the serial output bit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         db_q    <= 8'h00;
         sr_q    <= 8'h00;
         shcnt_q <= 4'd0;
         data_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         sr_q    <= sr_d;
         shcnt_q <= shcnt_d;
         data_q  <= data_d;
      end
   end

   assign ctlr.ctlr_data = data_q;
   assign buttons_db     = db_q;
   assign shift_cnt      = shcnt_q;

endmodule

// File: tb/tb_nes_pad_serializer.sv
// Directed bench for nes_pad_serializer with DEBOUNCE_CYCLES = 4: a vector table for the
// main reset/latch/read sequence plus hand-written multi-cycle corner cases.
module tb_nes_pad_serializer;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] buttons_raw = 8'h00;
   logic [7:0] buttons_db;
   logic [3:0] shift_cnt;
   int         checks = 0;
   int         errors = 0;

   nes_pad_serializer_if bus ();

   nes_pad_serializer #(.DEBOUNCE_CYCLES(4)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .buttons_raw (buttons_raw),
      .ctlr        (bus),
      .buttons_db  (buttons_db),
      .shift_cnt   (shift_cnt)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       latch;
      logic       pulse;
      logic [7:0] raw;
      logic       exp_data;
      logic [3:0] exp_cnt;
      logic [7:0] exp_db;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic d, input logic [3:0] c, input logic [7:0] db);
      check({tag, "_data"}, {7'd0, bus.ctlr_data}, {7'd0, d});
      check({tag, "_cnt"}, {4'd0, shift_cnt}, {4'd0, c});
      check({tag, "_db"}, buttons_db, db);
   endtask

   task automatic step(input logic l, input logic p);
      bus.ctlr_latch = l;
      bus.ctlr_pulse = p;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      bus.ctlr_latch = 1'b0;
      bus.ctlr_pulse = 1'b0;
      buttons_raw    = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      check_all("reset", 1'b1, 4'd0, 8'h00);
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset, 9 reads without latch: idle bit 1, count saturates at 8
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd1, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd2, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd3, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd4, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd5, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd6, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd7, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 4'd8, 8'h00});
      // Raw 8'h09 held: accepted on the 6th clock, not the 5th
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h09, 1'b1, 4'd8, 8'h09});
      // One-clock latch then 9 reads: A=0, then 1,1,0,1,1,1,1, then idle 1s
      vecs.push_back('{1'b1, 1'b0, 8'h09, 1'b0, 4'd0, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd1, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd2, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b0, 4'd3, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd4, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd5, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd6, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd7, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd8, 8'h09});
      vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b1, 4'd8, 8'h09});

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         buttons_raw = vecs[i].raw;
         step(vecs[i].latch, vecs[i].pulse);
         check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_cnt, vecs[i].exp_db);
      end

      // Glitch: bit0 high for 3 clocks never reaches buttons_db
      do_reset();
      buttons_raw = 8'h01;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0);
         check("glitch_high_db", buttons_db, 8'h00);
      end
      buttons_raw = 8'h00;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0);
         check("glitch_low_db", buttons_db, 8'h00);
      end

      // Latch and pulse together: latch wins, no shift
      buttons_raw = 8'h02;
      repeat (6) step(1'b0, 1'b0);
      check("btn_b_db", buttons_db, 8'h02);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("pre_latch_cnt", {4'd0, shift_cnt}, 8'd2);
      step(1'b1, 1'b1);
      check_all("latch_pulse", 1'b1, 4'd0, 8'h02);
      step(1'b0, 1'b1);
      check_all("after_latch_b", 1'b0, 4'd1, 8'h02);

      // SR frozen against buttons_db changes while latch is low
      buttons_raw = 8'hFF;
      repeat (6) step(1'b0, 1'b0);
      check("all_pressed_db", buttons_db, 8'hFF);
      step(1'b1, 1'b0);
      check_all("ff_latch", 1'b0, 4'd0, 8'hFF);
      for (int p = 1; p <= 3; p++) begin
         step(1'b0, 1'b1);
         check_all($sformatf("ff_read%0d", p), 1'b0, 4'(p), 8'hFF);
      end
      buttons_raw = 8'h00;
      repeat (6) step(1'b0, 1'b0);
      check_all("frozen_release", 1'b0, 4'd3, 8'h00);
      for (int p = 4; p <= 7; p++) begin
         step(1'b0, 1'b1);
         check_all($sformatf("frozen_read%0d", p), 1'b0, 4'(p), 8'h00);
      end
      step(1'b0, 1'b1);
      check_all("frozen_read8", 1'b1, 4'd8, 8'h00);
      step(1'b0, 1'b1);
      check_all("frozen_read9", 1'b1, 4'd8, 8'h00);

      // Reset in the middle of a shift sequence
      do_reset();
      buttons_raw = 8'hFF;
      repeat (6) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b1);
      check_all("pre_reset", 1'b0, 4'd4, 8'hFF);
      bus.ctlr_pulse = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check_all("async_reset", 1'b1, 4'd0, 8'h00);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      step(1'b0, 1'b1);
      check_all("post_reset_read", 1'b1, 4'd1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nes_pad_serializer.md
NES_PAD_SERIALIZER -- requirements
Module: nes_pad_serializer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable clocks required to accept a button change (legal range 1..65535).
REQ-002 SHALL have port clock, input, 1, system master clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port buttons_raw, input, 8, asynchronous active-high pad inputs {Right,Left,Down,Up,Start,Select,B,A} (bit0 = A).
REQ-005 SHALL have port ctlr_latch, input, 1, strobe level driven from the $4016 bit0 write path, synchronous to clock.
REQ-006 SHALL have port ctlr_pulse, input, 1, single-clock read strobe, asserted once per CPU read of the port, synchronous to clock.
REQ-007 SHALL have port ctlr_data, output, 1, serial pad bit toward cpu_memory ctlr_data_p1/p2; 0 = pressed, 1 = released/idle.
REQ-008 SHALL have port buttons_db, output, 8, debounced active-high button state for debug.
REQ-009 SHALL have port shift_cnt, output, 4, reads since last latch, saturating at 8.

Function
REQ-010 SHALL pass each buttons_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep one counter per button; the counter clears whenever the synchronized bit equals buttons_db.
REQ-012 SHALL increment a button's counter on each clock where the synchronized bit differs from buttons_db.
REQ-013 SHALL toggle buttons_db[i] and clear counter i on the clock edge where counter i would reach DEBOUNCE_CYCLES, giving raw-to-buttons_db latency of exactly 2 + DEBOUNCE_CYCLES clocks for a stable change.
REQ-014 SHALL restart debouncing from zero when a glitch shorter than DEBOUNCE_CYCLES clocks occurs, leaving buttons_db unchanged.
REQ-015 SHALL hold an 8-bit active-high shift register SR; ctlr_data = ~SR[0].
REQ-016 SHALL, while ctlr_latch = 1, load SR from buttons_db every clock and force shift_cnt = 0; ctlr_data therefore tracks A live.
REQ-017 SHALL, while ctlr_latch = 1, ignore ctlr_pulse; latch wins on simultaneous assertion.
REQ-018 SHALL, on ctlr_pulse = 1 with ctlr_latch = 0, shift SR right by one with 0 entering bit7, and increment shift_cnt saturating at 8.
REQ-019 SHALL present the next bit on ctlr_data the clock after the pulse, so the CPU samples A, B, Select, Start, Up, Down, Left, Right on successive reads.
REQ-020 SHALL return ctlr_data = 1 for every read after the eighth until the next latch.
REQ-021 SHALL freeze SR contents against buttons_db changes while ctlr_latch = 0; only pulses modify SR.
REQ-022 SHALL treat a ctlr_latch high of any length, including one clock, as a full reload.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear synchronizers, counters, buttons_db, SR, and shift_cnt, giving ctlr_data = 1, buttons_db = 8'h00, shift_cnt = 0.
REQ-024 SHALL abort any in-progress debounce or shift sequence on reset mid-operation; the first post-reset read without a latch returns 1.
REQ-025 SHALL, once reset_n deasserts, resume operation on the first clock edge with no extra idle cycles.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Reset then 8 pulses with no latch -> ctlr_data = 1 throughout, shift_cnt = 8, buttons_db = 8'h00.
REQ-027 buttons_raw = 8'h09 held, wait 6 clocks, then latch 1 clock, then 8 pulses -> buttons_db = 8'h09 at clock 6 (not 5); ctlr_data sequence 0,1,1,0,1,1,1,1; ninth and tenth reads = 1.
REQ-028 buttons_raw bit0 high for 3 clocks then low -> buttons_db stays 8'h00.
REQ-029 Latch and pulse asserted together with buttons_db = 8'h02 -> no shift, ctlr_data = 1 (A released), shift_cnt = 0; after latch drop, first pulse gives ctlr_data = 0 (B).
REQ-030 Latch with buttons_db = 8'hFF, 3 pulses, raw changes to 8'h00 and debounces, 5 more pulses -> reads stay 0 for all 8 bits (SR frozen), then 1.
REQ-031 Reset asserted after 4 pulses of pattern 8'hFF -> ctlr_data = 1 immediately, shift_cnt = 0, buttons_db = 8'h00.
